// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records which of WIDTH cover points have fired and
// drains newly-hit indices, lowest first, one per valid/ready handshake.
module cover_toggle_collector #(
  parameter int WIDTH       = 44,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 28338,
  parameter int STICKY      = 1,
  parameter int IDX_W       = 64,
  parameter int CNT_W       = 16,
  localparam int HC_W       = $clog2(WIDTH + 1),
  localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [WIDTH-1:0]  valid,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [IDX_W-1:0]  rpt_index,
  output logic [HC_W-1:0]   hit_count,
  output logic              all_covered,
  output logic [CNT_W-1:0]  coalesced
);

  if ((COVER_INDEX + WIDTH > COVER_TOTAL) || (WIDTH < 1)) begin : g_param_err
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL or WIDTH < 1");
  end

  function automatic logic [SEL_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  function automatic logic [HC_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + HC_W'(v[i]);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [HC_W-1:0]  b);
    logic [CNT_W+HC_W-1:0] s;
    s = (CNT_W + HC_W)'(a) + (CNT_W + HC_W)'(b);
    if (|s[CNT_W+HC_W-1:CNT_W]) sat_add = '1;
    else                        sat_add = s[CNT_W-1:0];
  endfunction

  logic [WIDTH-1:0] seen;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] hit_p0;
  logic [WIDTH-1:0] new_p0;
  logic [WIDTH-1:0] cand_p0;
  logic [WIDTH-1:0] seen_nxt_p0;
  logic [WIDTH-1:0] onehot_p0;
  logic [SEL_W-1:0] sel_p0;
  logic [HC_W-1:0]  cnt_nxt_p0;
  logic [HC_W-1:0]  coal_inc_p0;
  logic             load_p0;

  // Stage 0: sample hits, form the candidate set and pick the lowest index
  always_comb begin
    hit_p0      = en ? valid : '0;
    new_p0      = (STICKY != 0) ? (hit_p0 & ~seen) : hit_p0;
    cand_p0     = pending | new_p0;
    seen_nxt_p0 = seen | hit_p0;
    cnt_nxt_p0  = popcnt(seen_nxt_p0);
    sel_p0      = lowest_set(cand_p0);
    onehot_p0   = WIDTH'(1) << sel_p0;
    load_p0     = !rpt_valid || rpt_ready;
    coal_inc_p0 = (STICKY != 0) ? '0 : popcnt(hit_p0 & pending);
  end

  // Stage 1: coverage state, report register and counters
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      seen        <= '0;
      pending     <= '0;
      rpt_valid   <= 1'b0;
      rpt_index   <= '0;
      hit_count   <= '0;
      all_covered <= 1'b0;
      coalesced   <= '0;
    end else begin
      seen        <= seen_nxt_p0;
      hit_count   <= cnt_nxt_p0;
      all_covered <= (cnt_nxt_p0 == HC_W'(WIDTH));
      coalesced   <= sat_add(coalesced, coal_inc_p0);
      if (load_p0) begin
        rpt_valid <= |cand_p0;
        rpt_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel_p0);
        pending   <= cand_p0 & ~onehot_p0;
      end else begin
        pending   <= cand_p0;
      end
    end
  end

endmodule
